// File: rtl/fp_exec_pipe_ctrl_if.sv
// fp_exec_pipe_ctrl_if: issue, recovery, div/sqrt handshake and writeback signals of the FP exec control pipe
interface fp_exec_pipe_ctrl_if #(
  parameter int LANES = 2,
  parameter int DEPTH = 5,
  parameter int PTR_W = 6,
  parameter int PAYLOAD_W = 64
);
  logic stall;
  logic clear;
  logic [LANES-1:0] in_valid;
  logic [LANES-1:0] in_reg_valid;
  logic [LANES-1:0] in_is_divsqrt;
  logic [LANES-1:0] in_replay;
  logic [LANES*PTR_W-1:0] in_ptr;
  logic [LANES*PAYLOAD_W-1:0] in_payload;
  logic rec_active;
  logic rec_flush_all;
  logic [PTR_W-1:0] rec_head;
  logic [PTR_W-1:0] rec_tail;
  logic [LANES-1:0] ds_done;
  logic [LANES-1:0] ds_req;
  logic [LANES-1:0] ds_abort;
  logic [LANES-1:0] ds_free;
  logic [LANES-1:0] replay_req;
  logic [LANES*PAYLOAD_W-1:0] replay_payload;
  logic [LANES-1:0] out_valid;
  logic [LANES-1:0] out_reg_valid;
  logic [LANES-1:0] out_is_divsqrt;
  logic [LANES*PAYLOAD_W-1:0] out_payload;
  logic [LANES*DEPTH-1:0] stage_valid;
  modport master (
    output stall, clear, in_valid, in_reg_valid, in_is_divsqrt, in_replay, in_ptr, in_payload,
           rec_active, rec_flush_all, rec_head, rec_tail, ds_done,
    input  ds_req, ds_abort, ds_free, replay_req, replay_payload, out_valid, out_reg_valid,
           out_is_divsqrt, out_payload, stage_valid
  );
  modport slave (
    input  stall, clear, in_valid, in_reg_valid, in_is_divsqrt, in_replay, in_ptr, in_payload,
           rec_active, rec_flush_all, rec_head, rec_tail, ds_done,
    output ds_req, ds_abort, ds_free, replay_req, replay_payload, out_valid, out_reg_valid,
           out_is_divsqrt, out_payload, stage_valid
  );
endinterface

// File: rtl/fp_exec_pipe_ctrl.sv
// fp_exec_pipe_ctrl: FP exec-stage op token pipeline with flush, replay and div/sqrt reservation (ports: clk, rst, bus slave)
module fp_exec_pipe_ctrl #(
  parameter int LANES = 2,
  parameter int DEPTH = 5,
  parameter int PTR_W = 6,
  parameter int PAYLOAD_W = 64
) (
  input logic clk,
  input logic rst,
  fp_exec_pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} ds_state_t;
  logic stall, clear, rec_active, rec_flush_all;
  logic [PTR_W-1:0] head, tail;
  assign stall = bus.stall;
  assign clear = bus.clear;
  assign rec_active = bus.rec_active;
  assign rec_flush_all = bus.rec_flush_all;
  assign head = bus.rec_head;
  assign tail = bus.rec_tail;
  function automatic logic flush(input logic [PTR_W-1:0] p);
    logic in_range;
    in_range = head < tail ? (p >= head && p < tail) : head > tail ? (p >= head || p < tail) : 1'b0;
    return rec_active && (rec_flush_all || in_range);
  endfunction
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ds_state_t st;
    logic [PTR_W-1:0] own, iptr;
    logic [DEPTH-1:0] vld, rv, dsf;
    logic [DEPTH-1:0][PTR_W-1:0] ptr;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] pay;
    logic [DEPTH-2:0] fl;
    logic start, abort, rel, rv0;
    assign iptr = bus.in_ptr[i*PTR_W +: PTR_W];
    always_comb
      for (int j = 0; j < DEPTH-1; j++)
        fl[j] = flush(ptr[j]);
    assign start = st == IDLE && bus.in_valid[i] && bus.in_is_divsqrt[i] && bus.in_reg_valid[i] &&
                   !bus.in_replay[i] && !flush(iptr) && !stall;
    assign abort = st != IDLE && flush(own);
    assign rel = st == DONE && vld[DEPTH-1] && dsf[DEPTH-1] && rv[DEPTH-1] && ptr[DEPTH-1] == own && !stall;
    // a div/sqrt op only carries a valid result when it is the replay of the op that owns a finished unit
    assign rv0 = bus.in_is_divsqrt[i] ? bus.in_replay[i] && st == DONE && own == iptr : bus.in_reg_valid[i];
    always_ff @(posedge clk)
      if (rst) begin
        vld <= '0;
        rv <= '0;
        st <= IDLE;
      end else begin
        if (clear) begin
          vld <= '0;
          rv <= '0;
        end else if (!stall) begin
          vld <= {vld[DEPTH-2:0] & ~fl, bus.in_valid[i]};
          rv <= {rv[DEPTH-2:0], rv0};
        end
        st <= abort ? IDLE : start ? BUSY : st == BUSY && bus.ds_done[i] ? DONE : rel ? IDLE : st;
        if (start) own <= iptr;
      end
    always_ff @(posedge clk)
      if (!stall) begin
        dsf <= {dsf[DEPTH-2:0], bus.in_is_divsqrt[i]};
        ptr <= {ptr[DEPTH-2:0], iptr};
        pay <= {pay[DEPTH-2:0], bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W]};
      end
    assign bus.ds_req[i] = start && !rst;
    assign bus.ds_abort[i] = abort && !rst;
    assign bus.ds_free[i] = st == IDLE;
    assign bus.replay_req[i] = !stall && !clear && !rst && vld[1] && !rv[1] && !fl[1];
    assign bus.replay_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay[1];
    assign bus.out_valid[i] = !stall && !clear && !rst && vld[DEPTH-1] && !flush(ptr[DEPTH-1]);
    assign bus.out_reg_valid[i] = rv[DEPTH-1];
    assign bus.out_is_divsqrt[i] = dsf[DEPTH-1];
    assign bus.out_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay[DEPTH-1];
    assign bus.stage_valid[i*DEPTH +: DEPTH] = vld;
  end
endmodule

// File: tb/tb_fp_exec_pipe_ctrl.sv
// tb_fp_exec_pipe_ctrl: directed and random checks of fp_exec_pipe_ctrl against a token-list reference model
module tb_fp_exec_pipe_ctrl;
  localparam int L = 2;
  localparam int D = 5;
  localparam int PW = 6;
  localparam int YW = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_exec_pipe_ctrl_if #(.LANES(L), .DEPTH(D), .PTR_W(PW), .PAYLOAD_W(YW)) bus();
  fp_exec_pipe_ctrl #(.LANES(L), .DEPTH(D), .PTR_W(PW), .PAYLOAD_W(YW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int lane;
    logic [PW-1:0] ptr;
    logic [YW-1:0] pay;
    logic rv;
    logic ds;
    int age;
  } op_t;
  op_t ops[$];
  int dst[L];
  logic [PW-1:0] own[L];
  int n_vec = 0;
  int n_err = 0;
  function automatic bit fm(input logic [PW-1:0] p);
    logic [PW-1:0] off, span;
    off = p - bus.rec_head;
    span = bus.rec_tail - bus.rec_head;
    return bus.rec_active && (bus.rec_flush_all || off < span);
  endfunction
  function automatic bit want_req(input int l);
    return dst[l] == 0 && bus.in_valid[l] && bus.in_is_divsqrt[l] && bus.in_reg_valid[l] &&
           !bus.in_replay[l] && !fm(bus.in_ptr[l*PW +: PW]) && !bus.stall;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr_in();
    bus.stall = 1'b0;
    bus.clear = 1'b0;
    bus.in_valid = '0;
    bus.in_reg_valid = '0;
    bus.in_is_divsqrt = '0;
    bus.in_replay = '0;
    bus.in_ptr = '0;
    bus.in_payload = '0;
    bus.rec_active = 1'b0;
    bus.rec_flush_all = 1'b0;
    bus.rec_head = '0;
    bus.rec_tail = '0;
    bus.ds_done = '0;
  endtask
  task automatic issue(input int l, input logic [PW-1:0] p, input logic [YW-1:0] d, input bit r, input bit ds, input bit rep);
    bus.in_valid[l] = 1'b1;
    bus.in_reg_valid[l] = r;
    bus.in_is_divsqrt[l] = ds;
    bus.in_replay[l] = rep;
    bus.in_ptr[l*PW +: PW] = p;
    bus.in_payload[l*YW +: YW] = d;
  endtask
  task automatic flush_rng(input logic [PW-1:0] h, input logic [PW-1:0] t, input bit all);
    bus.rec_active = 1'b1;
    bus.rec_flush_all = all;
    bus.rec_head = h;
    bus.rec_tail = t;
  endtask
  task automatic cyc();
    logic [L*D-1:0] e_sv;
    logic [L-1:0] e_ov, e_rr;
    bit live;
    bit rel[L];
    op_t nq[$];
    op_t n;
    @(negedge clk);
    live = !bus.stall && !bus.clear && !rst;
    e_sv = '0;
    e_ov = '0;
    e_rr = '0;
    foreach (ops[k]) begin
      e_sv[ops[k].lane*D + ops[k].age] = 1'b1;
      if (ops[k].age == D-1) begin
        e_ov[ops[k].lane] = live && !fm(ops[k].ptr);
        chk("out_reg_valid", 128'(bus.out_reg_valid[ops[k].lane]), 128'(ops[k].rv));
        chk("out_is_divsqrt", 128'(bus.out_is_divsqrt[ops[k].lane]), 128'(ops[k].ds));
        chk("out_payload", 128'(bus.out_payload[ops[k].lane*YW +: YW]), 128'(ops[k].pay));
      end
      if (ops[k].age == 1) begin
        e_rr[ops[k].lane] = live && !ops[k].rv && !fm(ops[k].ptr);
        if (e_rr[ops[k].lane]) chk("replay_payload", 128'(bus.replay_payload[ops[k].lane*YW +: YW]), 128'(ops[k].pay));
      end
    end
    chk("stage_valid", 128'(bus.stage_valid), 128'(e_sv));
    chk("out_valid", 128'(bus.out_valid), 128'(e_ov));
    chk("replay_req", 128'(bus.replay_req), 128'(e_rr));
    for (int l = 0; l < L; l++) begin
      chk("ds_req", 128'(bus.ds_req[l]), 128'(!rst && want_req(l)));
      chk("ds_abort", 128'(bus.ds_abort[l]), 128'(!rst && dst[l] != 0 && fm(own[l])));
      chk("ds_free", 128'(bus.ds_free[l]), 128'(dst[l] == 0));
    end
    @(posedge clk);
    if (rst) begin
      ops.delete();
      for (int l = 0; l < L; l++) dst[l] = 0;
    end else begin
      for (int l = 0; l < L; l++) rel[l] = 1'b0;
      foreach (ops[k])
        if (ops[k].age == D-1 && ops[k].ds && ops[k].rv && dst[ops[k].lane] == 2 &&
            ops[k].ptr == own[ops[k].lane] && !bus.stall) rel[ops[k].lane] = 1'b1;
      if (bus.clear) ops.delete();
      else if (!bus.stall) begin
        foreach (ops[k])
          if (!fm(ops[k].ptr) && ops[k].age < D-1) begin
            n = ops[k];
            n.age++;
            nq.push_back(n);
          end
        for (int l = 0; l < L; l++)
          if (bus.in_valid[l]) begin
            n.lane = l;
            n.ptr = bus.in_ptr[l*PW +: PW];
            n.pay = bus.in_payload[l*YW +: YW];
            n.ds = bus.in_is_divsqrt[l];
            n.rv = n.ds ? (bus.in_replay[l] && dst[l] == 2 && own[l] == n.ptr) : bus.in_reg_valid[l];
            n.age = 0;
            nq.push_back(n);
          end
        ops = nq;
      end
      for (int l = 0; l < L; l++)
        if (dst[l] != 0 && fm(own[l])) dst[l] = 0;
        else if (want_req(l)) begin
          dst[l] = 1;
          own[l] = bus.in_ptr[l*PW +: PW];
        end else if (dst[l] == 1 && bus.ds_done[l]) dst[l] = 2;
        else if (rel[l]) dst[l] = 0;
    end
    #1;
  endtask
  initial begin
    logic [PW-1:0] p;
    bit ds, rep;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < L; l++) dst[l] = 0;
    cyc();
    rst = 1'b0;
    clr_in(); issue(0, 6'd3, 64'hA5A5_0000_1111_2222, 1'b1, 1'b0, 1'b0); cyc();
    clr_in(); repeat (6) cyc();
    clr_in(); issue(1, 6'd4, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0); cyc();
    clr_in(); repeat (6) cyc();
    clr_in(); issue(0, 6'd61, 64'h61, 1'b1, 1'b0, 1'b0); cyc();
    clr_in(); issue(0, 6'd1, 64'h01, 1'b1, 1'b0, 1'b0); cyc();
    clr_in(); issue(0, 6'd5, 64'h05, 1'b1, 1'b0, 1'b0); cyc();
    clr_in(); flush_rng(6'd60, 6'd2, 1'b0); cyc();
    clr_in(); repeat (5) cyc();
    clr_in(); issue(1, 6'd9, 64'h09, 1'b1, 1'b0, 1'b0); cyc();
    clr_in(); issue(1, 6'd10, 64'h0A, 0, 1'b0, 1'b0); cyc();
    clr_in(); flush_rng(6'd9, 6'd9, 1'b0); cyc();
    clr_in(); repeat (5) cyc();
    clr_in(); issue(0, 6'd20, 64'hD1D1, 1'b1, 1'b1, 1'b0); cyc();
    clr_in(); repeat (11) cyc();
    clr_in(); bus.ds_done[0] = 1'b1; cyc();
    clr_in(); repeat (2) cyc();
    clr_in(); issue(0, 6'd20, 64'hD2D2, 1'b1, 1'b1, 1'b1); cyc();
    clr_in(); repeat (6) cyc();
    clr_in(); issue(1, 6'd30, 64'h3030, 1'b1, 1'b1, 1'b0); cyc();
    clr_in(); repeat (3) cyc();
    clr_in(); flush_rng(6'd30, 6'd31, 1'b0); cyc();
    clr_in(); repeat (2) cyc();
    clr_in(); bus.ds_done[1] = 1'b1; cyc();
    clr_in(); repeat (3) cyc();
    clr_in(); issue(0, 6'd40, 64'h4040, 1'b1, 1'b0, 1'b0); cyc();
    clr_in(); issue(1, 6'd41, 64'h4141, 1'b0, 1'b0, 1'b0); cyc();
    clr_in(); cyc();
    clr_in(); bus.stall = 1'b1; issue(0, 6'd42, 64'h4242, 1'b1, 1'b0, 1'b0); repeat (3) cyc();
    clr_in(); bus.clear = 1'b1; cyc();
    clr_in(); repeat (3) cyc();
    clr_in(); issue(0, 6'd50, 64'h5050, 1'b1, 1'b1, 1'b0); cyc();
    clr_in(); repeat (2) cyc();
    clr_in(); rst = 1'b1; flush_rng(6'd0, 6'd0, 1'b1); cyc();
    rst = 1'b0;
    clr_in(); repeat (2) cyc();
    for (int s = 0; s < 400; s++) begin
      clr_in();
      bus.stall = $urandom_range(0, 5) == 0;
      bus.clear = $urandom_range(0, 19) == 0;
      for (int l = 0; l < L; l++)
        if ($urandom_range(0, 1) == 1) begin
          p = PW'($urandom);
          ds = $urandom_range(0, 2) == 0;
          rep = $urandom_range(0, 3) == 0;
          if (dst[l] == 2 && $urandom_range(0, 1) == 1) begin
            p = own[l];
            ds = 1'b1;
            rep = 1'b1;
          end
          issue(l, p, {$urandom, $urandom}, $urandom_range(0, 3) != 0, ds, rep);
        end
      bus.ds_done = L'($urandom);
      if ($urandom_range(0, 7) == 0) flush_rng(PW'($urandom), PW'($urandom), $urandom_range(0, 3) == 0);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
